multiplicador_seq: RTL

MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

---
 rtl/multiplicador_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/multiplicador_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier that performs every addition
// on an external 4-bit ripple adder. Define MULT_BACK2BACK_EN to accept start in DONE.
module multiplicador_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_s,
    input  logic       add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] m;
    logic [3:0] q;
    logic [3:0] acc;
    logic [1:0] cnt;

    logic [3:0] acc_next;
    logic [3:0] q_next;
    logic       accept;

    // The 5-bit adder result is shifted right one place across {acc, q}.
    assign acc_next = {add_cout, add_s[3:1]};
    assign q_next   = {add_s[0], q[3:1]};

`ifdef MULT_BACK2BACK_EN
    assign accept = start && ((state == IDLE) || (state == DONE));
`else
    assign accept = start && (state == IDLE);
`endif

    // The adder sees only registered state, so no output follows start, a or b.
    assign add_a   = (state == ADD) ? acc : 4'h0;
    assign add_b   = ((state == ADD) && q[0]) ? m : 4'h0;
    assign add_cin = 1'b0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= 4'h0;
            q     <= 4'h0;
            acc   <= 4'h0;
            cnt   <= 2'd0;
            p     <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        m     <= a;
                        q     <= b;
                        acc   <= 4'h0;
                        cnt   <= 2'd0;
                        state <= ADD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ADD: begin
                    acc <= acc_next;
                    q   <= q_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        p     <= {acc_next, q_next};
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
